// File: rtl/secuenciador_etapas_pid_pkg.sv
// Shared definitions for the PID stage sequencer: FSM state codes,
// stage index constants and the stage-index to strobe decoder.
package secuenciador_etapas_pid_pkg;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADC_REQ  = 3'd1,
        ST_ADC_WAIT = 3'd2,
        ST_STAGE    = 3'd3,
        ST_DAC_XFER = 3'd4
    } estado_e;

    // Stage indices: etapa1 is index 0, etapa5 (store yant) is the last one
    localparam logic [2:0] ETAPA_PRIMERA = 3'd0;
    localparam logic [2:0] ETAPA_ULTIMA  = 3'd4;

    // Map a stage index onto its one-hot strobe vector (bit 0 = etapa1)
    function automatic logic [4:0] etapa_onehot(input logic [2:0] idx);
        logic [4:0] vec;
        case (idx)
            3'd0:    vec = 5'b00001;
            3'd1:    vec = 5'b00010;
            3'd2:    vec = 5'b00100;
            3'd3:    vec = 5'b01000;
            3'd4:    vec = 5'b10000;
            default: vec = 5'b00000;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/secuenciador_etapas_pid_divisor_muestreo.sv
// Sample-rate divider: counts 0..SAMPLE_DIV-1 while enabled and flags the
// terminal count with a one-cycle tick. Disabling holds the count at zero.
module divisor_muestreo #(
    parameter int unsigned SAMPLE_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear when disabled or at terminal count, else increment
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/secuenciador_etapas_pid.sv
// PID stage sequencer: per sample tick it requests an ADC conversion, waits
// for the result (with timeout), fires etapa1..etapa5 in order, then hands
// the control word to the DAC with a valid/ready transfer. Overruns and ADC
// timeouts are reported through sticky flags. All outputs are registered.
module secuenciador_etapas_pid
    import secuenciador_etapas_pid_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV  = 1000,
    parameter int unsigned STAGE_GAP   = 1,
    parameter int unsigned ADC_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic adc_done,
    input  logic dac_ready,
    input  logic clr_err,
    output logic adc_start,
    output logic etapa1,
    output logic etapa2,
    output logic etapa3,
    output logic etapa4,
    output logic etapa5,
    output logic dac_load,
    output logic busy,
    output logic overrun,
    output logic adc_err
);

    localparam int WAIT_W = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT) : 1;
    localparam int GAP_W  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ADC_TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);

    logic tick_s;

    estado_e           state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [2:0]        etapa_idx_q, etapa_idx_d;
    logic              timeout_s;
    logic              overrun_set_s;

    logic       adc_start_q, adc_start_d;
    logic [4:0] etapa_q, etapa_d;
    logic       dac_load_q, dac_load_d;
    logic       busy_q, busy_d;
    logic       overrun_q, overrun_d;
    logic       adc_err_q, adc_err_d;

    divisor_muestreo #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_divisor (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en),
        .tick_o (tick_s)
    );

    // FSM state and sequencing counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            etapa_idx_q <= ETAPA_PRIMERA;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            etapa_idx_q <= etapa_idx_d;
        end
    end

    // Next-state logic; ticks outside IDLE are ignored here (overrun path)
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        etapa_idx_d = etapa_idx_q;
        timeout_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick_s) begin
                    state_d = ST_ADC_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADC_REQ: begin
                state_d    = ST_ADC_WAIT;
                wait_cnt_d = '0;
            end
            ST_ADC_WAIT: begin
                if (adc_done) begin
                    state_d     = ST_STAGE;
                    etapa_idx_d = ETAPA_PRIMERA;
                    gap_cnt_d   = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_s = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_STAGE: begin
                // The last strobe hands over to the DAC on the very next cycle
                if (etapa_idx_q == ETAPA_ULTIMA) begin
                    state_d = ST_DAC_XFER;
                end else if (gap_cnt_q == GAP_LAST) begin
                    etapa_idx_d = etapa_idx_q + 3'd1;
                    gap_cnt_d   = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            ST_DAC_XFER: begin
                if (dac_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DAC_XFER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so outputs line up with state_q
    always_comb begin
        adc_start_d   = (state_d == ST_ADC_REQ);
        dac_load_d    = (state_d == ST_DAC_XFER);
        busy_d        = (state_d != ST_IDLE);
        overrun_set_s = tick_s && (state_q != ST_IDLE);
        if ((state_d == ST_STAGE) && (gap_cnt_d == '0)) begin
            etapa_d = etapa_onehot(etapa_idx_d);
        end else begin
            etapa_d = 5'b00000;
        end
        // Sticky flags: a set event outranks a simultaneous clear
        if (overrun_set_s) begin
            overrun_d = 1'b1;
        end else if (clr_err) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
        if (timeout_s) begin
            adc_err_d = 1'b1;
        end else if (clr_err) begin
            adc_err_d = 1'b0;
        end else begin
            adc_err_d = adc_err_q;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            adc_start_q <= 1'b0;
            etapa_q     <= 5'b00000;
            dac_load_q  <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            adc_err_q   <= 1'b0;
        end else begin
            adc_start_q <= adc_start_d;
            etapa_q     <= etapa_d;
            dac_load_q  <= dac_load_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            adc_err_q   <= adc_err_d;
        end
    end

    assign adc_start = adc_start_q;
    assign etapa1    = etapa_q[0];
    assign etapa2    = etapa_q[1];
    assign etapa3    = etapa_q[2];
    assign etapa4    = etapa_q[3];
    assign etapa5    = etapa_q[4];
    assign dac_load  = dac_load_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
    assign adc_err   = adc_err_q;

endmodule
